// File: rtl/mem_port_arbiter.sv
// Shares the single cacheline memory port between icache and dcache.
// One transaction at a time; ties alternate so neither cache starves.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state  | meaning
  // IDLE   | arbitrate between pending requests
  // I_MEM  | icache line read in flight
  // D_MEM  | dcache read or writeback in flight
  // I_RESP | one-cycle completion pulse to icache
  // D_RESP | one-cycle completion pulse to dcache
  typedef enum logic [2:0] {IDLE, I_MEM, D_MEM, I_RESP, D_RESP} state_t;

  state_t              r_state;
  logic                r_last_gnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_line;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic                r_i_resp;
  logic                r_d_resp;

  logic                w_i_req;
  logic                w_d_req;
  logic                w_pick_i;
  logic                w_unused_addr_bits;

  assign w_i_req  = i_read;
  assign w_d_req  = d_read | d_write;
  // On a tie the cache not served last wins; last_gnt=0 favours dcache.
  assign w_pick_i = w_i_req & (~w_d_req | r_last_gnt);
  assign w_unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_gnt   <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_line       <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_i) begin
            r_state      <= I_MEM;
            r_addr       <= {i_addr[ADDR_W-1:5], 5'b0};
            r_write      <= 1'b0;
            r_pmem_read  <= 1'b1;
            r_pmem_write <= 1'b0;
          end else if (w_d_req) begin
            // d_read together with d_write is resolved as a writeback.
            r_state      <= D_MEM;
            r_addr       <= {d_addr[ADDR_W-1:5], 5'b0};
            r_write      <= d_write;
            r_pmem_read  <= ~d_write;
            r_pmem_write <= d_write;
            if (d_write) r_wdata <= d_wdata;
          end
        end
        I_MEM: begin
          if (pmem_resp) begin
            r_state     <= I_RESP;
            r_line      <= pmem_rdata;
            r_pmem_read <= 1'b0;
            r_i_resp    <= 1'b1;
          end
        end
        D_MEM: begin
          if (pmem_resp) begin
            r_state      <= D_RESP;
            if (!r_write) r_line <= pmem_rdata;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_d_resp     <= 1'b1;
          end
        end
        I_RESP: begin
          r_state    <= IDLE;
          r_i_resp   <= 1'b0;
          r_last_gnt <= 1'b0;
        end
        D_RESP: begin
          r_state    <= IDLE;
          r_d_resp   <= 1'b0;
          r_last_gnt <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
          r_i_resp     <= 1'b0;
          r_d_resp     <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata    = r_line;
  assign d_rdata    = r_line;
  assign i_resp     = r_i_resp;
  assign d_resp     = r_d_resp;
  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations plus a
// protocol monitor running through a random request stress.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  localparam logic [255:0] LINE_BEEF = {8{32'hDEADBEEF}};
  localparam logic [255:0] LINE_A5   = {8{32'hA5A5A5A5}};
  localparam logic [255:0] LINE_5A   = {8{32'h5A5A5A5A}};

  mem_port_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds pmem_resp low for wait_cyc cycles, then pulses it with data.
  task automatic reply(input logic [255:0] data, input int wait_cyc);
    repeat (wait_cyc) tick();
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    tick();
    pmem_resp  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {252'd0, pmem_read, pmem_write, i_resp, d_resp}, 256'd0);
    chk({tag, "_addr"}, {224'd0, pmem_addr}, 256'd0);
    chk({tag, "_wdata"}, pmem_wdata, 256'd0);
    chk({tag, "_rdata"}, i_rdata | d_rdata, 256'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      assert (!(pmem_read && pmem_write)) else begin
        bad++;
        $error("FAIL rw_excl observed=%0b%0b expected=not_both", pmem_read, pmem_write);
      end
      total++;
      assert (!(i_resp && d_resp)) else begin
        bad++;
        $error("FAIL resp_onehot observed=%0b%0b expected=not_both", i_resp, d_resp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [31:0]  exp_addr;
    logic [255:0] line_v;

    rst = 1'b0; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: lone icache read
    i_read = 1'b1; i_addr = 32'h0000_1044;
    tick();
    chk("t1_pread", {255'd0, pmem_read}, 256'd1);
    chk("t1_pwrite", {255'd0, pmem_write}, 256'd0);
    chk("t1_addr", {224'd0, pmem_addr}, {224'd0, 32'h0000_1040});
    repeat (3) tick();
    chk("t1_pread_held", {255'd0, pmem_read}, 256'd1);
    tick();
    pmem_resp = 1'b1; pmem_rdata = LINE_BEEF;
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    chk("t1_iresp", {255'd0, i_resp}, 256'd1);
    chk("t1_irdata", i_rdata, LINE_BEEF);
    chk("t1_dresp", {255'd0, d_resp}, 256'd0);
    chk("t1_pread_off", {255'd0, pmem_read}, 256'd0);
    tick();
    chk("t1_iresp_pulse", {255'd0, i_resp}, 256'd0);

    // 2: dcache writeback with inputs changing mid-flight
    d_write = 1'b1; d_addr = 32'h8000_0020; d_wdata = LINE_A5;
    tick();
    chk("t2_pwrite", {255'd0, pmem_write}, 256'd1);
    chk("t2_pread", {255'd0, pmem_read}, 256'd0);
    chk("t2_addr", {224'd0, pmem_addr}, {224'd0, 32'h8000_0020});
    chk("t2_wdata", pmem_wdata, LINE_A5);
    d_wdata = LINE_5A; d_addr = 32'h1234_5660;
    tick();
    chk("t2_wdata_stable", pmem_wdata, LINE_A5);
    chk("t2_addr_stable", {224'd0, pmem_addr}, {224'd0, 32'h8000_0020});
    reply(LINE_5A, 2);
    d_write = 1'b0;
    chk("t2_dresp", {255'd0, d_resp}, 256'd1);
    chk("t2_line_kept", d_rdata, LINE_BEEF);
    chk("t2_pwrite_off", {255'd0, pmem_write}, 256'd0);
    tick();
    chk("t2_dresp_pulse", {255'd0, d_resp}, 256'd0);

    // 3: simultaneous requests after reset alternate D, I, D, I
    rst = 1'b0;
    #1;
    chk_all_zero("t3_reset");
    tick();
    rst = 1'b1;
    tick();
    i_read = 1'b1; i_addr = 32'h0000_0100;
    d_read = 1'b1; d_addr = 32'h0000_0200;
    for (int r = 0; r < 4; r++) begin
      tick();
      exp_addr = (r % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
      chk($sformatf("t3_gnt%0d", r), {224'd0, pmem_addr}, {224'd0, exp_addr});
      chk($sformatf("t3_pread%0d", r), {255'd0, pmem_read}, 256'd1);
      line_v = {8{32'h1111_0000 + 32'(r)}};
      reply(line_v, 1);
      if (r == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end
      chk($sformatf("t3_resp%0d", r), {254'd0, i_resp, d_resp},
          (r % 2 == 0) ? 256'd1 : 256'd2);
      chk($sformatf("t3_data%0d", r), (r % 2 == 0) ? d_rdata : i_rdata, line_v);
      tick();
      chk($sformatf("t3_idle%0d", r), {254'd0, pmem_read, pmem_write}, 256'd0);
    end
    tick();

    // 4: async reset while D_MEM is active
    d_read = 1'b1; d_addr = 32'h0000_0300;
    tick();
    chk("t4_pread", {255'd0, pmem_read}, 256'd1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("t4_async");
    d_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | d_resp | pmem_read | pmem_write;
    end
    chk("t4_no_resp", {255'd0, seen}, 256'd0);
    i_read = 1'b1; i_addr = 32'h0000_041F;
    tick();
    chk("t4_iaddr", {224'd0, pmem_addr}, {224'd0, 32'h0000_0400});
    chk("t4_pread_i", {255'd0, pmem_read}, 256'd1);
    reply(LINE_A5, 2);
    i_read = 1'b0;
    chk("t4_iresp", {255'd0, i_resp}, 256'd1);
    chk("t4_idata", i_rdata, LINE_A5);
    tick();

    // 5: icache withdraws mid-transaction
    i_read = 1'b1; i_addr = 32'h0000_0500;
    tick();
    tick(); tick();
    i_read = 1'b0;
    chk("t5_pread_hold", {255'd0, pmem_read}, 256'd1);
    reply(LINE_BEEF, 2);
    chk("t5_iresp", {255'd0, i_resp}, 256'd1);
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | pmem_read | pmem_write | i_resp | d_resp;
    end
    chk("t5_quiet", {255'd0, seen}, 256'd0);

    // 6: read+write together is a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0600; d_wdata = LINE_5A;
    tick();
    chk("t6_rw", {254'd0, pmem_read, pmem_write}, 256'd1);
    chk("t6_wdata", pmem_wdata, LINE_5A);
    reply(LINE_A5, 1);
    d_read = 1'b0; d_write = 1'b0;
    chk("t6_dresp", {255'd0, d_resp}, 256'd1);
    chk("t6_line_kept", d_rdata, LINE_BEEF);
    tick();

    // random stress under the protocol monitor
    for (int k = 0; k < 300; k++) begin
      i_read     = 1'($urandom_range(0, 1));
      d_read     = 1'($urandom_range(0, 1));
      d_write    = 1'($urandom_range(0, 1));
      i_addr     = $urandom;
      d_addr     = $urandom;
      d_wdata    = {8{$urandom}};
      pmem_rdata = {8{$urandom}};
      pmem_resp  = ($urandom_range(0, 3) == 0);
      tick();
    end
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    repeat (4) tick();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
